// File: rtl/subleq_sequencer.sv
// subleq_sequencer: control FSM for a SUBLEQ processor datapath.
// Each instruction fetches operands a, b, c (pc, pc+1, pc+2), reads mem[a] and mem[b],
// computes the result, writes mem[b], then loads pc with c (branch taken) or pc+3.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   start                leave IDLE and begin an instruction at the current pc
//   mem_ack              memory completes the current access this cycle
//   zero, negative       ALU flags of the registered result (used only in UPD_PC)
//   c_eq_pc              operand c equals the current instruction address
//   a_ld .. result_ld    datapath register load enables (one-cycle pulses)
//   mem_rd, mem_wr       memory request strobes, held until mem_ack
//   addr_sel             address source: 0=pc 1=pc+1 2=pc+2 3=a 4=b
//   pc_ld, pc_sel        pc load enable; pc source 0=pc+3 1=c
//   busy, halted, err    status; state_o is the current state code
//   instr_cnt            instructions retired since reset (wraps)
module subleq_sequencer #(
   parameter int unsigned BRANCH_MODE = 0,
   parameter int unsigned STEP_MODE   = 0,
   parameter int unsigned TIMEOUT     = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mem_ack,
   input  logic             zero,
   input  logic             negative,
   input  logic             c_eq_pc,
   output logic             a_ld,
   output logic             b_ld,
   output logic             c_ld,
   output logic             mem_a_ld,
   output logic             mem_b_ld,
   output logic             result_ld,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [2:0]       addr_sel,
   output logic             pc_ld,
   output logic             pc_sel,
   output logic             busy,
   output logic             halted,
   output logic             err,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] instr_cnt
);

   typedef enum logic [3:0] {
      StIdle  = 4'd0,
      StRdA   = 4'd1,
      StRdB   = 4'd2,
      StRdC   = 4'd3,
      StRdMa  = 4'd4,
      StRdMb  = 4'd5,
      StExec  = 4'd6,
      StWb    = 4'd7,
      StUpdPc = 4'd8,
      StHalt  = 4'd9,
      StErr   = 4'd10
   } state_e;

   // Wide enough to hold TIMEOUT itself.
   localparam int unsigned WaitW = $clog2(TIMEOUT + 2);

   state_e             state_q, state_d;
   logic [WaitW-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               taken;

   assign taken = (BRANCH_MODE == 0) ? (zero | negative) : negative;

   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      cnt_d     = cnt_q;
      a_ld      = 1'b0;
      b_ld      = 1'b0;
      c_ld      = 1'b0;
      mem_a_ld  = 1'b0;
      mem_b_ld  = 1'b0;
      result_ld = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      addr_sel  = 3'd0;
      pc_ld     = 1'b0;
      pc_sel    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) state_d = StRdA;
         end
         StRdA: begin
            mem_rd   = 1'b1;
            addr_sel = 3'd0;
            if (mem_ack) begin
               a_ld    = 1'b1;
               state_d = StRdB;
            end
         end
         StRdB: begin
            mem_rd   = 1'b1;
            addr_sel = 3'd1;
            if (mem_ack) begin
               b_ld    = 1'b1;
               state_d = StRdC;
            end
         end
         StRdC: begin
            mem_rd   = 1'b1;
            addr_sel = 3'd2;
            if (mem_ack) begin
               c_ld    = 1'b1;
               state_d = StRdMa;
            end
         end
         StRdMa: begin
            mem_rd   = 1'b1;
            addr_sel = 3'd3;
            if (mem_ack) begin
               mem_a_ld = 1'b1;
               state_d  = StRdMb;
            end
         end
         StRdMb: begin
            mem_rd   = 1'b1;
            addr_sel = 3'd4;
            if (mem_ack) begin
               mem_b_ld = 1'b1;
               state_d  = StExec;
            end
         end
         StExec: begin
            result_ld = 1'b1;
            state_d   = StWb;
         end
         StWb: begin
            mem_wr   = 1'b1;
            addr_sel = 3'd4;
            if (mem_ack) state_d = StUpdPc;
         end
         StUpdPc: begin
            pc_ld  = 1'b1;
            pc_sel = taken;
            cnt_d  = cnt_q + CNT_W'(1);
            // A taken branch to itself can never make progress.
            if (taken && c_eq_pc)   state_d = StHalt;
            else if (STEP_MODE != 0) state_d = StIdle;
            else                    state_d = StRdA;
         end
         StHalt, StErr: ;
         default: state_d = StIdle;
      endcase

      // Watchdog: an ack in the limit cycle still completes the access.
      if ((mem_rd || mem_wr) && !mem_ack) begin
         if (TIMEOUT != 0 && wait_q == WaitW'(TIMEOUT)) state_d = StErr;
         else                                           wait_d  = wait_q + WaitW'(1);
      end

      // Reset drops any outstanding request and suppresses loads in the same cycle.
      if (rst) begin
         a_ld      = 1'b0;
         b_ld      = 1'b0;
         c_ld      = 1'b0;
         mem_a_ld  = 1'b0;
         mem_b_ld  = 1'b0;
         result_ld = 1'b0;
         mem_rd    = 1'b0;
         mem_wr    = 1'b0;
         pc_ld     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         wait_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o   = state_q;
   assign busy      = (state_q != StIdle) && (state_q != StHalt) && (state_q != StErr);
   assign halted    = (state_q == StHalt);
   assign err       = (state_q == StErr);
   assign instr_cnt = cnt_q;

endmodule
